gray_ptr_tracker: RTL and testbench

- Receive side of the team's gray-coded pointer scheme; pairs with the binary-to-gray encoder on the producer side.
- Samples a gray-coded pointer that has already been synchronized into the local domain and decodes it to binary.
- Accumulates the number of increments seen since the consumer last collected them, and presents that count on a valid/ready interface.
- Checks that consecutive samples differ in at most one bit, which is the gray-code invariant. Typical use: read-side occupancy and credit tracking of a CDC FIFO.

---
 rtl/gray_ptr_tracker.sv | 129 ++++++++++++
 tb/tb_gray_ptr_tracker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_tracker.sv
// gray_ptr_tracker
// Receive-side tracker for a gray-coded pointer that has already been
// synchronized into the local clock domain.
//   - Decodes each captured gray sample to binary (bin_o).
//   - Accumulates forward steps between captures and offers the total on a
//     valid/ready interface (delta_o / delta_valid_o / delta_ready_i).
//   - Flags captures that differ from the previous capture in more than one
//     bit (err_o, sticky) and accumulator saturation (ovf_o, sticky).
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   gray_i         gray-coded pointer, read only when sample_i=1
//   sample_i       capture strobe for gray_i
//   clear_i        synchronous soft clear back to INIT
//   bin_o          binary decode of the last captured gray value
//   delta_o        accumulated increment count since the last handshake
//   delta_valid_o  delta_o is nonzero
//   delta_ready_i  consumer accepts delta_o
//   err_o          sticky multi-bit-change flag
//   ovf_o          sticky accumulator saturation flag
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | no baseline yet; the next capture only records the pointer
// TRACK | baseline held; captures produce steps and are error-checked

module gray_ptr_tracker #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] gray_i,
  input  logic         sample_i,
  input  logic         clear_i,
  output logic [N-1:0] bin_o,
  output logic [N-1:0] delta_o,
  output logic         delta_valid_o,
  input  logic         delta_ready_i,
  output logic         err_o,
  output logic         ovf_o
);

  if (N < 1) begin : g_bad_width
    $error("gray_ptr_tracker: N must be at least 1");
  end

  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  localparam logic [N-1:0] ONE = N'(1);

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [0:0]   state;
  logic [N-1:0] prev_gray;

  logic [N-1:0] dec;
  logic [N-1:0] diff;
  logic         hd_zero;
  logic         hd_one;
  logic         hd_multi;
  logic         take;
  logic [N-1:0] step;
  logic         handshake;
  logic [N-1:0] base;
  logic [N:0]   sum;
  logic         sat;
  logic [N-1:0] acc_next;

  always_comb begin
    dec       = gray2bin(gray_i);
    diff      = gray_i ^ prev_gray;
    hd_zero   = (diff == '0);
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    hd_one    = !hd_zero && ((diff & (diff - ONE)) == '0);
    hd_multi  = !hd_zero && !hd_one;
    take      = sample_i && (state == TRACK);
    // Modular subtraction makes the 2^N-1 -> 0 wrap a step of 1.
    step      = (take && hd_one) ? (dec - bin_o) : '0;
    handshake = delta_valid_o && delta_ready_i;
    // On a handshake the old total leaves; a same-cycle step starts the next one.
    base      = handshake ? '0 : delta_o;
    sum       = {1'b0, base} + {1'b0, step};
    sat       = sum[N];
    acc_next  = sat ? '1 : sum[N-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= INIT;
      prev_gray     <= '0;
      bin_o         <= '0;
      delta_o       <= '0;
      delta_valid_o <= 1'b0;
      err_o         <= 1'b0;
      ovf_o         <= 1'b0;
    end else if (clear_i) begin
      // bin_o and prev_gray are deliberately kept.
      state         <= INIT;
      delta_o       <= '0;
      delta_valid_o <= 1'b0;
      err_o         <= 1'b0;
      ovf_o         <= 1'b0;
    end else begin
      delta_o       <= acc_next;
      delta_valid_o <= (acc_next != '0);
      if (sat) begin
        ovf_o <= 1'b1;
      end
      if (sample_i) begin
        bin_o     <= dec;
        prev_gray <= gray_i;
        state     <= TRACK;
        if (take && hd_multi) begin
          err_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_ptr_tracker.sv
module tb_gray_ptr_tracker;

  localparam int N   = 4;
  localparam int MAX = (1 << N) - 1;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] gray_i;
  logic         sample_i;
  logic         clear_i;
  logic [N-1:0] bin_o;
  logic [N-1:0] delta_o;
  logic         delta_valid_o;
  logic         delta_ready_i;
  logic         err_o;
  logic         ovf_o;

  gray_ptr_tracker #(.N(N)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .gray_i        (gray_i),
    .sample_i      (sample_i),
    .clear_i       (clear_i),
    .bin_o         (bin_o),
    .delta_o       (delta_o),
    .delta_valid_o (delta_valid_o),
    .delta_ready_i (delta_ready_i),
    .err_o         (err_o),
    .ovf_o         (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int bin;
    int delta;
    int valid;
    int err;
    int ovf;
  } exp_t;

  exp_t exp_q[$];

  int compared   = 0;
  int mismatched = 0;

  // Reference model state, plain integers.
  bit m_tracking;
  int m_bin, m_prev, m_acc;
  bit m_err, m_ovf;

  // Binary bit i of a gray code is the parity of gray bits i and above.
  function automatic int to_bin(input int g);
    int b = 0;
    for (int i = 0; i < N; i++) begin
      if ($countones(g >> i) % 2 == 1) b += (1 << i);
    end
    return b;
  endfunction

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) & MAX;
  endfunction

  task automatic model(input bit rst, input bit clr, input bit smp, input int g, input bit rdy);
    int acc, st, d, hd;
    if (rst) begin
      m_tracking = 0; m_bin = 0; m_prev = 0; m_acc = 0; m_err = 0; m_ovf = 0;
    end else if (clr) begin
      m_tracking = 0; m_acc = 0; m_err = 0; m_ovf = 0;
    end else begin
      acc = (m_acc != 0 && rdy) ? 0 : m_acc;
      st  = 0;
      if (smp) begin
        d = to_bin(g);
        if (m_tracking) begin
          hd = $countones(g ^ m_prev);
          if (hd == 1) st = (d - m_bin + (MAX + 1)) % (MAX + 1);
          else if (hd > 1) m_err = 1;
        end
        m_bin = d; m_prev = g; m_tracking = 1;
      end
      acc += st;
      if (acc > MAX) begin
        acc = MAX; m_ovf = 1;
      end
      m_acc = acc;
    end
  endtask

  task automatic drive(input bit rst, input bit clr, input bit smp, input int g, input bit rdy);
    exp_t e;
    rst_i = rst; clear_i = clr; sample_i = smp; gray_i = g[N-1:0]; delta_ready_i = rdy;
    @(posedge clk_i);
    model(rst, clr, smp, g, rdy);
    e.bin = m_bin; e.delta = m_acc; e.valid = (m_acc != 0); e.err = m_err; e.ovf = m_ovf;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  // Monitor: every cycle the DUT presents registered outputs; compare them
  // against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bin_o",         int'(bin_o),         e.bin);
        chk("delta_o",       int'(delta_o),       e.delta);
        chk("delta_valid_o", int'(delta_valid_o), e.valid);
        chk("err_o",         int'(err_o),         e.err);
        chk("ovf_o",         int'(ovf_o),         e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    int r;
    rst_i = 1; clear_i = 0; sample_i = 0; gray_i = '0; delta_ready_i = 0;

    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Basic counting 0..3, then handshake with a same-cycle step.
    drive(0, 0, 1, 4'b0000, 0);
    drive(0, 0, 1, 4'b0001, 0);
    drive(0, 0, 1, 4'b0011, 0);
    drive(0, 0, 1, 4'b0010, 0);
    drive(0, 0, 1, 4'b0110, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);

    // Wrap-around 15 -> 0.
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 4'b1000, 0);
    drive(0, 0, 1, 4'b0000, 0);

    // Multi-bit jump then a legal step; also ready with nothing valid.
    drive(0, 1, 0, 0, 1);
    drive(0, 0, 1, 4'b0001, 1);
    drive(0, 0, 1, 4'b0111, 0);
    drive(0, 0, 1, 4'b0101, 0);
    drive(0, 0, 1, 4'b0101, 0);

    // Saturation: 16 single steps, then clear beating sample and ready.
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, to_gray(0), 0);
    for (int i = 1; i <= 16; i++) drive(0, 0, 1, to_gray(i & MAX), 0);
    drive(0, 1, 1, to_gray(1), 1);
    drive(0, 0, 1, to_gray(2), 0);
    drive(0, 0, 1, to_gray(3), 0);

    // Reset with delta pending.
    drive(0, 0, 1, to_gray(5), 0);
    drive(1, 0, 1, to_gray(6), 1);
    drive(0, 0, 1, to_gray(7), 0);
    drive(0, 0, 1, to_gray(8), 0);

    // Randomized traffic.
    cur = to_gray(8);
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      cur = cur ^ (1 << $urandom_range(0, N - 1));
      else if (r <= 7) cur = $urandom_range(0, MAX);
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 3) != 0), cur, ($urandom_range(0, 2) == 0));
    end

    drive(0, 0, 0, 0, 0);
    @(negedge clk_i);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
